// File: rtl/drum_trigger_queue_pkg.sv
// Shared types and constants for the drum trigger queue.
// Contents:
//   NUM_VOICES  number of drum voices
//   VEL_W       MIDI velocity width
//   voice_t     drum voice index enum
//   trigger_t   one buffered trigger {voice, velocity}
//   KEY_*       General MIDI percussion key numbers that map to a voice
package drum_pkg;

    localparam int NUM_VOICES = 8;
    localparam int VEL_W      = 7;

    typedef enum logic [2:0] {
        KICK       = 3'd0,
        SNARE      = 3'd1,
        HAT_CLOSED = 3'd2,
        HAT_OPEN   = 3'd3,
        CRASH      = 3'd4,
        RIDE       = 3'd5,
        TOM_HI     = 3'd6,
        TOM_LO     = 3'd7
    } voice_t;

    typedef struct packed {
        voice_t           voice;
        logic [VEL_W-1:0] velocity;
    } trigger_t;

    // General MIDI percussion keys
    localparam logic [6:0] KEY_KICK         = 7'd36;
    localparam logic [6:0] KEY_SNARE        = 7'd38;
    localparam logic [6:0] KEY_SNARE_ELEC   = 7'd40;
    localparam logic [6:0] KEY_TOM_LO_FLOOR = 7'd41;
    localparam logic [6:0] KEY_HAT_CLOSED   = 7'd42;
    localparam logic [6:0] KEY_TOM_HI_FLOOR = 7'd43;
    localparam logic [6:0] KEY_HAT_PEDAL    = 7'd44;
    localparam logic [6:0] KEY_TOM_LO       = 7'd45;
    localparam logic [6:0] KEY_HAT_OPEN     = 7'd46;
    localparam logic [6:0] KEY_TOM_LO_MID   = 7'd47;
    localparam logic [6:0] KEY_TOM_HI_MID   = 7'd48;
    localparam logic [6:0] KEY_CRASH1       = 7'd49;
    localparam logic [6:0] KEY_TOM_HI       = 7'd50;
    localparam logic [6:0] KEY_RIDE1        = 7'd51;
    localparam logic [6:0] KEY_CRASH2       = 7'd57;
    localparam logic [6:0] KEY_RIDE2        = 7'd59;

endpackage

// File: rtl/drum_trigger_queue_if.sv
// Handshake bundle for the drum trigger queue.
// Signals:
//   in_valid/in_key/in_velocity  note-on pulse from the MIDI decoder
//   out_valid/out_ready          trigger handshake to the playback engine
//   out_voice/out_velocity       head trigger payload
// Modports:
//   master  environment side (drives note-ons, accepts triggers)
//   slave   queue side
interface drum_trigger_queue_if #(
    parameter int VOICE_W = 3
);
    logic               in_valid;
    logic [6:0]         in_key;
    logic [6:0]         in_velocity;
    logic               out_valid;
    logic               out_ready;
    logic [VOICE_W-1:0] out_voice;
    logic [6:0]         out_velocity;

    modport master (
        output in_valid, in_key, in_velocity, out_ready,
        input  out_valid, out_voice, out_velocity
    );

    modport slave (
        input  in_valid, in_key, in_velocity, out_ready,
        output out_valid, out_voice, out_velocity
    );
endinterface

// File: rtl/drum_trigger_queue_trigger_fifo.sv
// Show-ahead synchronous FIFO of trigger_t.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write request (ignored when full unless popping)
//   push_data   entry to write
//   pop         read request (ignored when empty)
//   head        current head entry; holds the last head value when empty
//   full/empty  status
// Pointers carry one wrap bit: full when the wrap bits differ and the
// index bits match.
module trigger_fifo
    import drum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  trigger_t push_data,
    input  logic     pop,
    output trigger_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    trigger_t          mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]     occupancy;
    logic [AW-1:0]     rd_idx_next;
    trigger_t          head_reg, head_next;
    logic              do_push, do_pop;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign occupancy   = wr_ptr_reg - rd_ptr_reg;
    assign rd_idx_next = rd_ptr_reg[AW-1:0] + 1'b1;
    assign do_pop      = pop && !empty;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push     = push && (!full || do_pop);
    assign head        = head_reg;

    // The head is kept in its own register so the output is registered and
    // keeps the last head value once the FIFO drains.
    always_comb begin
        head_next = head_reg;
        if (do_pop) begin
            if (occupancy > PW'(1)) begin
                head_next = mem[rd_idx_next];
            end else if (do_push) begin
                head_next = push_data;
            end
        end else if (empty && do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            head_reg <= head_next;
        end
    end
endmodule

// File: rtl/drum_trigger_queue.sv
// Drum trigger queue: maps GM percussion note-ons to drum voices, drops
// unmapped keys and note-offs, buffers triggers for the playback engine.
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   bus         drum_trigger_queue_if.slave (note-on input, trigger output)
//   drop_count  saturating count of triggers lost to FIFO overflow
// Build option:
//   DRUM_VELOCITY_CURVE_EN  square-law velocity curve applied before storage
// Latency: note-on in cycle N appears on out_valid in cycle N+2 (empty FIFO).
module drum_trigger_queue
    import drum_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int VOICE_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    drum_trigger_queue_if.slave  bus,
    output logic [7:0]           drop_count
);
    voice_t     map_voice;
    logic       map_hit;
    logic [6:0] vel_curved;
    logic       map_valid_reg;
    trigger_t   map_entry_reg;
    logic [7:0] drop_count_reg;
    trigger_t   fifo_head;
    logic       fifo_full, fifo_empty;
    logic       pop;

    always_comb begin
        map_hit   = 1'b1;
        map_voice = KICK;
        case (bus.in_key)
            KEY_KICK:                       map_voice = KICK;
            KEY_SNARE, KEY_SNARE_ELEC:      map_voice = SNARE;
            KEY_HAT_CLOSED, KEY_HAT_PEDAL:  map_voice = HAT_CLOSED;
            KEY_HAT_OPEN:                   map_voice = HAT_OPEN;
            KEY_CRASH1, KEY_CRASH2:         map_voice = CRASH;
            KEY_RIDE1, KEY_RIDE2:           map_voice = RIDE;
            KEY_TOM_HI_MID, KEY_TOM_HI:     map_voice = TOM_HI;
            KEY_TOM_LO_FLOOR, KEY_TOM_HI_FLOOR,
            KEY_TOM_LO, KEY_TOM_LO_MID:     map_voice = TOM_LO;
            default:                        map_hit   = 1'b0;
        endcase
    end

`ifdef DRUM_VELOCITY_CURVE_EN
    logic [13:0] vel_sq;
    assign vel_sq = {7'd0, bus.in_velocity} * {7'd0, bus.in_velocity};

    // 127^2>>7 is 126, so full scale is pinned; soft hits never vanish.
    always_comb begin
        vel_curved = 7'(vel_sq >> 7);
        if (bus.in_velocity == 7'd127) begin
            vel_curved = 7'd127;
        end else if (vel_curved == 7'd0 && bus.in_velocity != 7'd0) begin
            vel_curved = 7'd1;
        end
    end
`else
    assign vel_curved = bus.in_velocity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_valid_reg <= 1'b0;
            map_entry_reg <= '0;
        end else begin
            map_valid_reg <= bus.in_valid && map_hit && (bus.in_velocity != 7'd0);
            if (bus.in_valid) begin
                map_entry_reg <= '{voice: map_voice, velocity: vel_curved};
            end
        end
    end

    assign pop = bus.out_valid && bus.out_ready;

    trigger_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (map_valid_reg),
        .push_data (map_entry_reg),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_reg <= 8'd0;
        end else if (map_valid_reg && fifo_full && !pop && drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count       = drop_count_reg;
    assign bus.out_valid    = !fifo_empty;
    assign bus.out_voice    = VOICE_W'(fifo_head.voice);
    assign bus.out_velocity = fifo_head.velocity;
endmodule

// File: tb/tb_drum_trigger_queue.sv
// Self-checking bench for drum_trigger_queue: scoreboard of expected
// triggers, checked as the queue hands them out.
module tb_drum_trigger_queue;

    typedef struct {
        int voice;
        int vel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drop_count;
    exp_t       sb[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    drum_trigger_queue_if #(.VOICE_W(3)) dut_if ();

    drum_trigger_queue #(
        .FIFO_DEPTH (4),
        .VOICE_W    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (dut_if),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_voice(input int key);
        if (key == 36) return 0;
        if (key == 38 || key == 40) return 1;
        if (key == 42 || key == 44) return 2;
        if (key == 46) return 3;
        if (key == 49 || key == 57) return 4;
        if (key == 51 || key == 59) return 5;
        if (key == 48 || key == 50) return 6;
        if (key == 41 || key == 43 || key == 45 || key == 47) return 7;
        return -1;
    endfunction

    function automatic int exp_vel(input int v);
        int r;
`ifdef DRUM_VELOCITY_CURVE_EN
        r = (v * v) / 128;
        if (v == 127) r = 127;
        else if (r == 0 && v > 0) r = 1;
`else
        r = v;
`endif
        return r;
    endfunction

    // Drive one note-on for a single cycle; the caller ends the pulse.
    task automatic pulse(input int key, input int vel, input bit push_exp);
        exp_t e;
        @(posedge clk);
        #1;
        dut_if.in_valid    = 1'b1;
        dut_if.in_key      = 7'(key);
        dut_if.in_velocity = 7'(vel);
        if (push_exp && ref_voice(key) >= 0 && vel > 0) begin
            e.voice = ref_voice(key);
            e.vel   = exp_vel(vel);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dut_if.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i = 0;
        while (sb.size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, sb.size(), 0);
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
    endtask

    // Consumer side: every accepted trigger must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dut_if.out_valid && dut_if.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_trigger", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("[TB] trigger voice=%0d vel=%0d (expect %0d/%0d)",
                         dut_if.out_voice, dut_if.out_velocity, e.voice, e.vel);
                check("out_voice", dut_if.out_voice, e.voice);
                check("out_velocity", dut_if.out_velocity, e.vel);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int keys[16] = '{36, 38, 40, 42, 44, 46, 49, 57, 51, 59, 48, 50, 41, 43, 45, 47};
        int cin[4]   = '{1, 10, 64, 127};
`ifdef DRUM_VELOCITY_CURVE_EN
        int cexp[4]  = '{1, 1, 32, 127};
`else
        int cexp[4]  = '{1, 10, 64, 127};
`endif
        exp_t e;

        dut_if.in_valid    = 1'b0;
        dut_if.in_key      = 7'd0;
        dut_if.in_velocity = 7'd0;
        dut_if.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", dut_if.out_valid, 0);
        check("rst_out_voice", dut_if.out_voice, 0);
        check("rst_out_velocity", dut_if.out_velocity, 0);
        check("rst_drop_count", drop_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single trigger latency: cycle N -> out_valid in N+2 for one cycle
        dut_if.out_ready = 1'b1;
        pulse(36, 100, 1);
        idle(1);
        check("lat_n1_valid", dut_if.out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_n2_valid", dut_if.out_valid, 1);
        check("lat_n2_voice", dut_if.out_voice, 0);
        check("lat_n2_vel", dut_if.out_velocity, exp_vel(100));
        @(posedge clk);
        #1;
        check("lat_n3_valid", dut_if.out_valid, 0);
        check("lat_sb_empty", sb.size(), 0);

        // Unmapped key and a note-off are both dropped silently
        pulse(60, 90, 0);
        pulse(38, 0, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("filter_no_valid", dut_if.out_valid, 0);
        end
        check("filter_drop_count", drop_count, 0);

        // Overflow: five triggers into a stalled depth-4 FIFO
        dut_if.out_ready = 1'b0;
        pulse(36, 20, 1);
        pulse(38, 40, 1);
        pulse(42, 60, 1);
        pulse(46, 80, 1);
        pulse(49, 100, 0);
        idle(3);
        check("ovf_drop_count", drop_count, 1);
        check("ovf_out_valid", dut_if.out_valid, 1);
        check("ovf_head_voice", dut_if.out_voice, 0);
        check("ovf_head_vel", dut_if.out_velocity, exp_vel(20));
        dut_if.out_ready = 1'b1;
        wait_drain("ovf_drain", 40);
        check("ovf_empty_after", dut_if.out_valid, 0);

        // Full FIFO with a pop in the same cycle as the write: no drop
        dut_if.out_ready = 1'b0;
        pulse(36, 30, 1);
        pulse(38, 31, 1);
        pulse(42, 32, 1);
        pulse(46, 33, 1);
        idle(3);
        pulse(51, 70, 1);
        @(posedge clk);
        #1;
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        wait_drain("fullpop_drain", 40);
        check("fullpop_drop_count", drop_count, 1);
        check("fullpop_empty_after", dut_if.out_valid, 0);

        // Every mapped key back-to-back, with unmapped keys interleaved
        for (int i = 0; i < 16; i++) begin
            pulse(keys[i], keys[i], 1);
            if (i == 5) pulse(37, 90, 1);
            if (i == 11) pulse(39, 90, 1);
        end
        idle(1);
        wait_drain("map_drain", 60);

        // Velocity curve points
        for (int i = 0; i < 4; i++) begin
            pulse(36, cin[i], 0);
            e.voice = 0;
            e.vel   = cexp[i];
            sb.push_back(e);
        end
        idle(1);
        wait_drain("curve_drain", 40);

        // Saturation of drop_count, then asynchronous reset mid-stream
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 310; i++) begin
            pulse(36, 50, 0);
        end
        idle(3);
        check("sat_drop_count", drop_count, 255);
        check("sat_out_valid", dut_if.out_valid, 1);
        pulse(38, 50, 0);
        pulse(42, 50, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", dut_if.out_valid, 0);
        check("arst_drop_count", drop_count, 0);
        check("arst_out_voice", dut_if.out_voice, 0);
        check("arst_out_velocity", dut_if.out_velocity, 0);
        @(negedge clk);
        dut_if.in_valid = 1'b0;
        rst = 1'b0;
        idle(4);
        check("post_rst_out_valid", dut_if.out_valid, 0);
        check("post_rst_drop_count", drop_count, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
